non_blocking_cache: RTL and testbench

- Direct-mapped, read-only, non-blocking data cache sitting between a requester and main memory.
- Hits return data one cycle after the request.
- Misses are recorded in a Miss Status Holding Register (MSHR) file of NUM_MISSES entries and forwarded to memory tagged with an op ID. Further requests keep being served while misses are outstanding.
- Memory returns (data, op) out of order; each return is matched to its MSHR entry, written into the cache, and the entry is freed.

---
 rtl/non_blocking_cache.sv | 242 ++++++++++++++++++++++++
 tb/tb_non_blocking_cache.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/non_blocking_cache.sv
// Direct-mapped, read-only, non-blocking cache: hits answer in one cycle, misses
// park in a small MSHR file and fill back out of order when memory returns by op ID.

module dm_cache #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int NUM_BLOCKS  = 8,
  parameter int NUM_OPS     = 32,
  parameter int BLOCK_DEPTH = 64,
  parameter int NUM_MISSES  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       read_enable,
  input  logic [ADDR_WIDTH-1:0]      read_address,
  input  logic [$clog2(NUM_OPS)-1:0] read_op,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [$clog2(NUM_OPS)-1:0] op_out,
  output logic                       hit,
  output logic                       miss,
  output logic                       stall,
  input  logic [DATA_WIDTH-1:0]      mm_ret_data,
  input  logic [$clog2(NUM_OPS)-1:0] mm_ret_op,
  input  logic                       mm_ret_valid,
  output logic [ADDR_WIDTH-1:0]      mm_req,
  output logic [$clog2(NUM_OPS)-1:0] mm_req_op,
  output logic                       mm_req_valid
);

  localparam int IDXW  = $clog2(NUM_BLOCKS);
  localparam int OPW   = $clog2(NUM_OPS);
  localparam int TAGW  = ADDR_WIDTH - IDXW;
  localparam int SLOTW = (NUM_MISSES > 1) ? $clog2(NUM_MISSES) : 1;
  localparam int RUNW  = $clog2(BLOCK_DEPTH + 2);

  logic [NUM_BLOCKS-1:0] line_valid;
  logic [TAGW-1:0]       line_tag  [NUM_BLOCKS];
  logic [DATA_WIDTH-1:0] line_data [NUM_BLOCKS];
  logic [OPW-1:0]        BLOCK_ops [NUM_BLOCKS];

  logic [NUM_MISSES-1:0] mshr_valid;
  logic [ADDR_WIDTH-1:0] mshr_addr [NUM_MISSES];
  logic [OPW-1:0]        mshr_op   [NUM_MISSES];

  logic                  received_request;
  logic [IDXW-1:0]       w_index;

  logic                  req_pending;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [OPW-1:0]        req_op;

  logic                  ret_pending;
  logic [DATA_WIDTH-1:0] ret_data;
  logic [OPW-1:0]        ret_op;
  logic [RUNW-1:0]       ret_run;

  logic [IDXW-1:0]       req_index;
  logic [TAGW-1:0]       req_tag;
  logic                  lookup_hit;
  logic                  alloc_found;
  logic [SLOTW-1:0]      alloc_slot;
  logic                  fill_found;
  logic [SLOTW-1:0]      fill_slot;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic [IDXW-1:0]       fill_index;
  logic [TAGW-1:0]       fill_tag;
  logic                  do_fill;

  assign req_index  = read_address[IDXW-1:0];
  assign req_tag    = read_address[ADDR_WIDTH-1:IDXW];
  assign lookup_hit = line_valid[req_index] && (line_tag[req_index] == req_tag);

  assign fill_addr  = mshr_addr[fill_slot];
  assign fill_index = fill_addr[IDXW-1:0];
  assign fill_tag   = fill_addr[ADDR_WIDTH-1:IDXW];
  assign do_fill    = ret_pending && fill_found;

  assign mm_req_valid = received_request;

  // Both searches scan downwards so the lowest qualifying entry wins.
  always_comb begin
    alloc_found = 1'b0;
    alloc_slot  = '0;
    fill_found  = 1'b0;
    fill_slot   = '0;
    for (int i = NUM_MISSES - 1; i >= 0; i--) begin
      if (!mshr_valid[i]) begin
        alloc_found = 1'b1;
        alloc_slot  = SLOTW'(i);
      end
      if (mshr_valid[i] && (mshr_op[i] == ret_op)) begin
        fill_found = 1'b1;
        fill_slot  = SLOTW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      line_valid       <= '0;
      mshr_valid       <= '0;
      hit              <= 1'b0;
      miss             <= 1'b0;
      stall            <= 1'b0;
      data_out         <= '0;
      op_out           <= '0;
      mm_req           <= '0;
      mm_req_op        <= '0;
      received_request <= 1'b0;
      req_pending      <= 1'b0;
      req_addr         <= '0;
      req_op           <= '0;
      ret_pending      <= 1'b0;
      ret_data         <= '0;
      ret_op           <= '0;
      ret_run          <= '0;
      w_index          <= '0;
      for (int b = 0; b < NUM_BLOCKS; b++) begin
        line_tag[b]  <= '0;
        line_data[b] <= '0;
        BLOCK_ops[b] <= '0;
      end
      for (int m = 0; m < NUM_MISSES; m++) begin
        mshr_addr[m] <= '0;
        mshr_op[m]   <= '0;
      end
    end else begin
      hit         <= 1'b0;
      miss        <= 1'b0;
      stall       <= 1'b0;
      data_out    <= '0;
      op_out      <= '0;
      req_pending <= 1'b0;

      if (read_enable) begin
        if (lookup_hit) begin
          hit      <= 1'b1;
          data_out <= line_data[req_index];
          op_out   <= read_op;
        end else begin
          miss <= 1'b1;
          if (alloc_found) begin
            mshr_valid[alloc_slot] <= 1'b1;
            mshr_addr[alloc_slot]  <= read_address;
            mshr_op[alloc_slot]    <= read_op;
            req_pending            <= 1'b1;
            req_addr               <= read_address;
            req_op                 <= read_op;
          end else begin
            stall <= 1'b1;
          end
        end
      end

      // Memory request goes out the cycle after the miss was recorded.
      received_request <= req_pending;
      if (req_pending) begin
        mm_req    <= req_addr;
        mm_req_op <= req_op;
      end

      ret_pending <= mm_ret_valid;
      ret_data    <= mm_ret_data;
      ret_op      <= mm_ret_op;
      if (!mm_ret_valid)
        ret_run <= '0;
      else if (ret_run != RUNW'(BLOCK_DEPTH + 1))
        ret_run <= ret_run + 1'b1;

      // Allocation only targets free entries and the fill only frees valid ones.
      if (do_fill) begin
        line_valid[fill_index] <= 1'b1;
        line_tag[fill_index]   <= fill_tag;
        line_data[fill_index]  <= ret_data;
        BLOCK_ops[fill_index]  <= ret_op;
        w_index                <= fill_index;
        mshr_valid[fill_slot]  <= 1'b0;
      end
    end
  end

  fill_records_op: assert property (@(posedge clk) disable iff (reset)
    $past(do_fill && !reset) |-> (BLOCK_ops[w_index] == $past(ret_op)));

  return_burst_bounded: assert property (@(posedge clk) disable iff (reset)
    ret_run <= RUNW'(BLOCK_DEPTH));

endmodule

module non_blocking_cache #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int NUM_BLOCKS  = 8,
  parameter int NUM_OPS     = 32,
  parameter int BLOCK_DEPTH = 64,
  parameter int NUM_MISSES  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       read_enable,
  input  logic [ADDR_WIDTH-1:0]      read_address,
  input  logic [$clog2(NUM_OPS)-1:0] read_op,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [$clog2(NUM_OPS)-1:0] op_out,
  output logic                       hit,
  output logic                       miss,
  output logic                       stall,
  input  logic [DATA_WIDTH-1:0]      mm_ret_data,
  input  logic [$clog2(NUM_OPS)-1:0] mm_ret_op,
  input  logic                       mm_ret_valid,
  output logic [ADDR_WIDTH-1:0]      mm_req,
  output logic [$clog2(NUM_OPS)-1:0] mm_req_op,
  output logic                       mm_req_valid
);

  dm_cache #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_BLOCKS (NUM_BLOCKS),
    .NUM_OPS    (NUM_OPS),
    .BLOCK_DEPTH(BLOCK_DEPTH),
    .NUM_MISSES (NUM_MISSES)
  ) DM_CACHE (
    .clk         (clk),
    .reset       (reset),
    .read_enable (read_enable),
    .read_address(read_address),
    .read_op     (read_op),
    .data_out    (data_out),
    .op_out      (op_out),
    .hit         (hit),
    .miss        (miss),
    .stall       (stall),
    .mm_ret_data (mm_ret_data),
    .mm_ret_op   (mm_ret_op),
    .mm_ret_valid(mm_ret_valid),
    .mm_req      (mm_req),
    .mm_req_op   (mm_req_op),
    .mm_req_valid(mm_req_valid)
  );

endmodule

// File: tb/tb_non_blocking_cache.sv
// Directed bench for non_blocking_cache: expected read responses and fills are queued
// as stimulus is driven and popped when the cache answers.

module tb_non_blocking_cache;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int OW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          read_enable;
  logic [AW-1:0] read_address;
  logic [OW-1:0] read_op;
  logic [DW-1:0] data_out;
  logic [OW-1:0] op_out;
  logic          hit;
  logic          miss;
  logic          stall;
  logic [DW-1:0] mm_ret_data;
  logic [OW-1:0] mm_ret_op;
  logic          mm_ret_valid;
  logic [AW-1:0] mm_req;
  logic [OW-1:0] mm_req_op;
  logic          mm_req_valid;

  non_blocking_cache dut (
    .clk         (clk),
    .reset       (reset),
    .read_enable (read_enable),
    .read_address(read_address),
    .read_op     (read_op),
    .data_out    (data_out),
    .op_out      (op_out),
    .hit         (hit),
    .miss        (miss),
    .stall       (stall),
    .mm_ret_data (mm_ret_data),
    .mm_ret_op   (mm_ret_op),
    .mm_ret_valid(mm_ret_valid),
    .mm_req      (mm_req),
    .mm_req_op   (mm_req_op),
    .mm_req_valid(mm_req_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [OW-1:0] op;
    logic          exp_hit;
    logic          exp_stall;
    logic [DW-1:0] exp_data;
  } rd_exp_t;

  typedef struct {
    logic [OW-1:0] op;
    logic [2:0]    index;
    int            pending;
  } ret_exp_t;

  rd_exp_t  rd_q[$];
  ret_exp_t ret_q[$];
  int total = 0;
  int bad   = 0;

  task automatic checkVal(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [AW-1:0] addr, input logic [OW-1:0] op,
                               input logic exp_hit, input logic exp_stall, input logic [DW-1:0] exp_data);
    rd_exp_t e;
    @(negedge clk);
    read_enable  = 1'b1;
    read_address = addr;
    read_op      = op;
    e = '{addr, op, exp_hit, exp_stall, exp_data};
    rd_q.push_back(e);
    @(posedge clk);
    #1;
    read_enable = 1'b0;
  endtask

  // Called just after the sampling edge; the memory request is checked one edge later.
  task automatic checkOutput();
    rd_exp_t e;
    logic    exp_req;
    if (rd_q.size() == 0) begin
      checkVal("rd_queue_empty", 64'd0, 64'd1);
      return;
    end
    e = rd_q.pop_front();
    checkVal("hit", 64'(hit), 64'(e.exp_hit));
    checkVal("miss", 64'(miss), 64'(!e.exp_hit));
    checkVal("stall", 64'(stall), 64'(e.exp_stall));
    if (e.exp_hit) begin
      checkVal("data_out", 64'(data_out), 64'(e.exp_data));
      checkVal("op_out", 64'(op_out), 64'(e.op));
    end
    exp_req = !e.exp_hit && !e.exp_stall;
    @(posedge clk);
    #1;
    checkVal("mm_req_valid", 64'(mm_req_valid), 64'(exp_req));
    checkVal("received_request", 64'(dut.DM_CACHE.received_request), 64'(exp_req));
    if (exp_req) begin
      checkVal("mm_req", 64'(mm_req), 64'(e.addr));
      checkVal("mm_req_op", 64'(mm_req_op), 64'(e.op));
    end
  endtask

  task automatic applyReturn(input logic [DW-1:0] data, input logic [OW-1:0] op,
                             input logic [2:0] index, input int pending);
    ret_exp_t r;
    @(negedge clk);
    mm_ret_valid = 1'b1;
    mm_ret_data  = data;
    mm_ret_op    = op;
    r = '{op, index, pending};
    ret_q.push_back(r);
    @(posedge clk);
    #1;
    mm_ret_valid = 1'b0;
  endtask

  task automatic checkFill();
    ret_exp_t r;
    if (ret_q.size() == 0) begin
      checkVal("ret_queue_empty", 64'd0, 64'd1);
      return;
    end
    r = ret_q.pop_front();
    @(posedge clk);
    #1;
    checkVal("w_index", 64'(dut.DM_CACHE.w_index), 64'(r.index));
    checkVal("block_op", 64'(dut.DM_CACHE.BLOCK_ops[r.index]), 64'(r.op));
    checkVal("mshr_count", 64'($countones(dut.DM_CACHE.mshr_valid)), 64'(r.pending));
  endtask

  initial begin
    reset        = 1'b1;
    read_enable  = 1'b0;
    read_address = '0;
    read_op      = '0;
    mm_ret_valid = 1'b0;
    mm_ret_data  = '0;
    mm_ret_op    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkVal("reset_outputs", {2'b0, hit, miss, stall, mm_req_valid, data_out, op_out, mm_req, mm_req_op}, 64'd0);
    checkVal("reset_lines", 64'(dut.DM_CACHE.line_valid), 64'd0);
    checkVal("reset_mshr", 64'(dut.DM_CACHE.mshr_valid), 64'd0);

    // Four cold misses fill the MSHR file.
    applyStimulus(16'h0001, 5'd10, 1'b0, 1'b0, '0); checkOutput();
    applyStimulus(16'h0002, 5'd11, 1'b0, 1'b0, '0); checkOutput();
    applyStimulus(16'h0003, 5'd12, 1'b0, 1'b0, '0); checkOutput();
    applyStimulus(16'h0004, 5'd13, 1'b0, 1'b0, '0); checkOutput();
    checkVal("mshr_full", 64'($countones(dut.DM_CACHE.mshr_valid)), 64'd4);

    applyReturn(32'hBBBB_BBBB, 5'd11, 3'd2, 3); checkFill();
    applyStimulus(16'h1005, 5'd14, 1'b0, 1'b0, '0); checkOutput();
    checkVal("mshr_refull", 64'($countones(dut.DM_CACHE.mshr_valid)), 64'd4);

    // Full MSHR: the miss is reported with stall and dropped.
    applyStimulus(16'hB006, 5'd15, 1'b0, 1'b1, '0); checkOutput();
    checkVal("stall_no_alloc", 64'($countones(dut.DM_CACHE.mshr_valid)), 64'd4);

    // Out-of-order returns.
    applyReturn(32'hCCCC_CCCC, 5'd12, 3'd3, 3); checkFill();
    applyReturn(32'hAAAA_AAAA, 5'd10, 3'd1, 2); checkFill();
    applyReturn(32'hDDDD_DDDD, 5'd13, 3'd4, 1); checkFill();
    applyReturn(32'hFFFF_FFFF, 5'd14, 3'd5, 0); checkFill();

    applyStimulus(16'h0004, 5'd20, 1'b1, 1'b0, 32'hDDDD_DDDD); checkOutput();
    applyStimulus(16'h1005, 5'd21, 1'b1, 1'b0, 32'hFFFF_FFFF); checkOutput();
    applyStimulus(16'h0003, 5'd22, 1'b1, 1'b0, 32'hCCCC_CCCC); checkOutput();
    applyStimulus(16'h0001, 5'd23, 1'b1, 1'b0, 32'hAAAA_AAAA); checkOutput();
    applyStimulus(16'h0002, 5'd25, 1'b1, 1'b0, 32'hBBBB_BBBB); checkOutput();

    // Same index, different tag, then reset while it is outstanding.
    applyStimulus(16'h2004, 5'd24, 1'b0, 1'b0, '0); checkOutput();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mm_ret_valid = 1'b1;
    mm_ret_data  = 32'h1234_5678;
    mm_ret_op    = 5'd24;
    @(posedge clk);
    #1;
    mm_ret_valid = 1'b0;
    @(posedge clk);
    #1;
    checkVal("late_ret_outputs", {2'b0, hit, miss, stall, mm_req_valid, data_out, op_out, mm_req, mm_req_op}, 64'd0);
    checkVal("late_ret_lines", 64'(dut.DM_CACHE.line_valid), 64'd0);
    checkVal("late_ret_mshr", 64'(dut.DM_CACHE.mshr_valid), 64'd0);
    checkVal("late_ret_w_index", 64'(dut.DM_CACHE.w_index), 64'd0);
    applyStimulus(16'h2004, 5'd26, 1'b0, 1'b0, '0); checkOutput();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
